seg7_scan_decoder: RTL and testbench

Receiving end of the stopwatch's multiplexed 4-digit seven-segment interface (seg/an).
- Samples the time-multiplexed, active-low segment and anode lines.
- Waits for each digit slot to settle, then decodes the segment pattern back to a digit code.
- Assembles complete 4-digit frames for checking by benches and on-chip self-test.
- Sits beside the stopwatch, on the same clock, observing its display outputs.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/seg7_scan_decoder.sv | 127 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns (gfedcba,
// active-low), decoded digit codes and the slot-capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } state_t;

    // True when exactly one anode line is pulled low.
    function automatic logic one_low(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low gfedcba pattern to a digit code
// (0-9, blank, or the unrecognised code).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_BAD;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed 4-digit seven-segment display (seg/an, active-low), waits
// for each digit slot to settle, decodes it and publishes complete 4-digit frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  code_err,
    output logic        frame_valid,
    output logic        an_err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [7:0]      seg_q, seg_p;
    logic [3:0]      an_q, an_p;
    logic [CW-1:0]   cnt;
    state_t          state, state_nx;
    logic            stable;
    logic            capture;
    logic            multi;
    logic [3:0]      code;
    logic [3:0]      seen, seen_nx;
    logic [3:0][3:0] shadow;
    logic [3:0]      shadow_dp;
    logic [3:0]      shadow_bad;

    seg7_pattern_decode u_decode (
        .pattern (seg_q[6:0]),
        .code    (code)
    );

    assign stable = ({seg_q, an_q} == {seg_p, an_p});

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        multi    = 1'b0;
        case (state)
            IDLE: begin
                if (an_q != AN_OFF) state_nx = SETTLING;
            end
            SETTLING: begin
                if (!stable) begin
                    state_nx = (an_q == AN_OFF) ? IDLE : SETTLING;
                end else if (cnt == CNT_LAST) begin
                    // Counter becomes SETTLE_CYCLES on this edge: the slot is settled.
                    state_nx = HELD;
                    capture  = one_low(an_q);
                    multi    = !one_low(an_q);
                end
            end
            HELD: begin
                if (!stable) state_nx = (an_q == AN_OFF) ? IDLE : SETTLING;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A capture in the completing cycle starts the next frame.
    always_comb begin
        seen_nx = (seen == 4'b1111) ? 4'b0000 : seen;
        if (capture) seen_nx = seen_nx | ~an_q;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) shadow_bad[k] = (shadow[k] == CODE_BAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= AN_OFF;
            seg_p <= 8'hFF;
            an_p  <= AN_OFF;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            seg_q <= seg;
            an_q  <= an;
            seg_p <= seg_q;
            an_p  <= an_q;
            state <= state_nx;
            if (!stable)             cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= 4'b0000;
            shadow      <= {4{CODE_BLANK}};
            shadow_dp   <= 4'b0000;
            digits      <= {4{CODE_BLANK}};
            dp          <= 4'b0000;
            code_err    <= 4'b0000;
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            seen   <= seen_nx;
            an_err <= multi;
            for (int k = 0; k < 4; k++) begin
                if (capture && !an_q[k]) begin
                    shadow[k]    <= code;
                    shadow_dp[k] <= ~seg_q[7];
                end
            end
            if (seen == 4'b1111) begin
                digits      <= shadow;
                dp          <= shadow_dp;
                code_err    <= shadow_bad;
                frame_valid <= 1'b1;
            end else begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table-driven frames plus hand-written corner
// sequences, with a frame scoreboard fed by the drivers and drained by a monitor.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  code_err;
    logic        frame_valid;
    logic        an_err;

    seg7_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .dp          (dp),
        .code_err    (code_err),
        .frame_valid (frame_valid),
        .an_err      (an_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bookkeeping
    int n_vec = 0;
    int n_err = 0;
    int an_err_seen = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_item;
    logic [15:0] last_digits;
    logic [6:0]  pat_tbl [10];

    typedef struct packed {
        logic [31:0] segs;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  code_err;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every frame_valid pulse must match the oldest pending frame.
    always @(posedge clk) begin
        #1;
        if (rst_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got digits=%h, no frame pending", digits);
            end else begin
                exp_item = exp_q.pop_front();
                check("frame_digits", {16'h0, digits}, {16'h0, exp_item[23:8]});
                check("frame_dp", {28'h0, dp}, {28'h0, exp_item[7:4]});
                check("frame_code_err", {28'h0, code_err}, {28'h0, exp_item[3:0]});
            end
        end
        if (rst_n && an_err) an_err_seen++;
    end

    // Driver tasks (entered and left on a falling edge)
    task automatic drive_raw(input logic [3:0] an_v, input logic [7:0] seg_v, input int cycles);
        an  = an_v;
        seg = seg_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_slot(input int k, input logic [7:0] seg_v, input int hold);
        logic [3:0] sel;
        sel = 4'b0001 << k;
        drive_raw(~sel, seg_v, hold);
    endtask

    task automatic blank(input int cycles);
        drive_raw(4'hF, 8'hFF, cycles);
    endtask

    task automatic scan_frame(input logic [31:0] segs, input int hold);
        for (int k = 0; k < 4; k++) drive_slot(k, segs[8*k +: 8], hold);
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] p, input logic [3:0] ce);
        exp_q.push_back({d, p, ce});
        last_digits = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, {16'h0, digits}, 32'h0000AAAA);
        check({tag, "_dp"}, {28'h0, dp}, 32'h0);
        check({tag, "_code_err"}, {28'h0, code_err}, 32'h0);
        check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
        check({tag, "_an_err"}, {31'h0, an_err}, 32'h0);
    endtask

    initial begin
        int an_base;
        int kind;
        int hold;
        logic [31:0] rsegs;
        logic [15:0] rdig;
        logic [3:0]  rdp;
        logic [3:0]  rce;
        logic [6:0]  pat;
        logic [6:0]  bad_pat [3];

        pat_tbl[0] = 7'h40; pat_tbl[1] = 7'h79; pat_tbl[2] = 7'h24; pat_tbl[3] = 7'h30;
        pat_tbl[4] = 7'h19; pat_tbl[5] = 7'h12; pat_tbl[6] = 7'h02; pat_tbl[7] = 7'h78;
        pat_tbl[8] = 7'h00; pat_tbl[9] = 7'h10;
        bad_pat[0] = 7'h55; bad_pat[1] = 7'h7E; bad_pat[2] = 7'h01;

        // segs[8k+7:8k] drives slot k
        vecs[0] = '{32'hF9A4B099, 16'h1234, 4'b0000, 4'b0000};
        vecs[1] = '{32'h9255F9C0, 16'h5F10, 4'b0100, 4'b0100};
        vecs[2] = '{32'h9282F880, 16'h5678, 4'b0000, 4'b0000};
        vecs[3] = '{32'hFF40107F, 16'hA09A, 4'b0111, 4'b0000};

        rst_n = 1'b1;
        seg   = 8'hFF;
        an    = 4'hF;
        last_digits = 16'hAAAA;

        // Asynchronous reset asserted mid-cycle
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        blank(3);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            push_exp(vecs[i].digits, vecs[i].dp, vecs[i].code_err);
            scan_frame(vecs[i].segs, 8);
            blank(2);
        end

        // Short glitch showing 8 in slot 0 before the real pattern
        push_exp(16'h1234, 4'b0000, 4'b0000);
        drive_raw(4'b1110, 8'h80, 2);
        scan_frame(vecs[0].segs, 8);
        blank(2);

        // Multi-hot anode in the middle of a frame
        an_base = an_err_seen;
        push_exp(16'h5678, 4'b0000, 4'b0000);
        drive_slot(0, vecs[2].segs[7:0], 8);
        drive_slot(1, vecs[2].segs[15:8], 8);
        drive_raw(4'b1100, 8'hC0, 8);
        check("an_err_pulses", an_err_seen - an_base, 1);
        drive_slot(2, vecs[2].segs[23:16], 8);
        drive_slot(3, vecs[2].segs[31:24], 8);
        blank(2);

        // Reset with three slots of a frame already captured
        drive_slot(0, vecs[0].segs[7:0], 8);
        drive_slot(1, vecs[0].segs[15:8], 8);
        drive_slot(2, vecs[0].segs[23:16], 8);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        blank(2);
        push_exp(16'h5678, 4'b0000, 4'b0000);
        scan_frame(vecs[2].segs, 8);
        blank(2);

        // Random frames with random hold times and blanking gaps
        for (int f = 0; f < 6; f++) begin
            rsegs = '0; rdig = '0; rdp = '0; rce = '0;
            for (int k = 0; k < 4; k++) begin
                kind = $urandom_range(0, 11);
                rdp[k] = 1'($urandom_range(0, 1));
                if (kind < 10) begin
                    pat = pat_tbl[kind];
                    rdig[4*k +: 4] = 4'(kind);
                end else if (kind == 10) begin
                    pat = 7'h7F;
                    rdig[4*k +: 4] = 4'hA;
                end else begin
                    pat = bad_pat[$urandom_range(0, 2)];
                    rdig[4*k +: 4] = 4'hF;
                    rce[k] = 1'b1;
                end
                rsegs[8*k +: 8] = {~rdp[k], pat};
            end
            push_exp(rdig, rdp, rce);
            for (int k = 0; k < 4; k++) begin
                hold = $urandom_range(7, 10);
                drive_slot(k, rsegs[8*k +: 8], hold);
                blank($urandom_range(0, 2));
            end
            blank(1);
        end

        // Drain and confirm outputs hold between frames
        blank(10);
        check("queue_drained", exp_q.size(), 0);
        check("digits_hold", {16'h0, digits}, {16'h0, last_digits});
        check("an_err_total", an_err_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
